// File: rtl/bus_resp_delay.sv
// Programmable response-delay stage: each accepted response is held for delay_cycles
// cycles in an in-order circular buffer before being offered downstream.
module bus_resp_delay #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic [31:0]                delay_cycles,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [31:0]       cnt_q  [DEPTH];
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [OW-1:0]     occ_q;
    logic [DEPTH-1:0]  live;
    logic              push;
    logic              pop;

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = ({1'b0, PW'(i) - rptr_q} < occ_q);
        end
    end

    assign s_ready   = (occ_q != OW'(DEPTH));
    assign m_valid   = (occ_q != '0) && (cnt_q[rptr_q] == 32'd0);
    assign m_data    = (occ_q != '0) ? data_q[rptr_q] : '0;
    assign occupancy = occ_q;
    assign busy      = (occ_q != '0);
    assign push      = s_valid && s_ready;
    assign pop       = m_valid && m_ready;

    // NOTE: the storage array is reset too, so no stale payload or count survives a reset.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (PW'(i) == wptr_q)) begin
                    data_q[i] <= s_data;
                    cnt_q[i]  <= delay_cycles;
                end else if (live[i] && (cnt_q[i] != 32'd0)) begin
                    cnt_q[i] <= cnt_q[i] - 32'd1;
                end
            end
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OW'(1);
                2'b01:   occ_q <= occ_q - OW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_resp_delay.sv
// Directed bench for bus_resp_delay: inputs change and outputs are sampled on the
// falling edge of pclk, one scenario task per feature.
module tb_bus_resp_delay;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [31:0] delay_cycles;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [2:0]  occupancy;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    bus_resp_delay #(.DATA_W(32), .DEPTH(4)) dut (
        .pclk(pclk), .presetn(presetn), .delay_cycles(delay_cycles),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .occupancy(occupancy), .busy(busy)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        presetn = 1'b0; delay_cycles = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        n_checks++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_zero_delay();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        delay_cycles = 32'd0; m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = vals[i];
            @(negedge pclk);
            n_checks++; if (m_valid !== 1'b1 || m_data !== vals[i]) begin n_fail++;
                $display("FAIL zero_delay_out%0d: got valid=%b data=%h want valid=1 data=%h", i, m_valid, m_data, vals[i]); end
            n_checks++; if (occupancy !== 3'd1) begin n_fail++;
                $display("FAIL zero_delay_occ%0d: got %0d want 1", i, occupancy); end
        end
        s_valid = 1'b0;
        @(negedge pclk);
        n_checks++; if (occupancy !== 3'd0 || m_valid !== 1'b0) begin n_fail++;
            $display("FAIL zero_delay_drain: got occ=%0d valid=%b want occ=0 valid=0", occupancy, m_valid); end
    endtask

    task automatic test_fixed_delay();
        delay_cycles = 32'd5; m_ready = 1'b1; s_valid = 1'b1; s_data = 32'hA5A5_A5A5;
        @(negedge pclk);
        s_valid = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            n_checks++; if (m_valid !== (k == 5)) begin n_fail++;
                $display("FAIL fixed_delay_valid_k%0d: got %b want %b", k, m_valid, (k == 5)); end
            n_checks++; if (busy !== 1'b1) begin n_fail++;
                $display("FAIL fixed_delay_busy_k%0d: got %b want 1", k, busy); end
            if (k == 5) begin
                n_checks++; if (m_data !== 32'hA5A5_A5A5) begin n_fail++;
                    $display("FAIL fixed_delay_data: got %h want a5a5a5a5", m_data); end
            end
            @(negedge pclk);
        end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++;
            $display("FAIL fixed_delay_drain: got occ=%0d want 0", occupancy); end
    endtask

    task automatic test_fill_full();
        int t;
        delay_cycles = 32'd10; m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (s_ready !== 1'b1) begin n_fail++;
                $display("FAIL fill_s_ready_before%0d: got %b want 1", i, s_ready); end
            s_valid = 1'b1; s_data = 32'h100 + i;
            @(negedge pclk);
        end
        n_checks++; if (s_ready !== 1'b0 || occupancy !== 3'd4) begin n_fail++;
            $display("FAIL fill_full: got s_ready=%b occ=%0d want s_ready=0 occ=4", s_ready, occupancy); end
        s_data = 32'h999;
        repeat (2) @(negedge pclk);
        n_checks++; if (occupancy !== 3'd4 || s_ready !== 1'b0) begin n_fail++;
            $display("FAIL fill_stall: got occ=%0d s_ready=%b want occ=4 s_ready=0", occupancy, s_ready); end
        s_valid = 1'b0;
        t = 0;
        while (m_valid !== 1'b1 && t < 20) begin @(negedge pclk); t++; end
        n_checks++; if (m_valid !== 1'b1 || m_data !== 32'h100) begin n_fail++;
            $display("FAIL fill_head: got valid=%b data=%h want valid=1 data=100 (waited %0d)", m_valid, m_data, t); end
        m_ready = 1'b1;
        @(negedge pclk);
        n_checks++; if (s_ready !== 1'b1 || occupancy !== 3'd3) begin n_fail++;
            $display("FAIL fill_reopen: got s_ready=%b occ=%0d want s_ready=1 occ=3", s_ready, occupancy); end
        for (int i = 1; i < 4; i++) begin
            n_checks++; if (m_valid !== 1'b1 || m_data !== 32'h100 + i) begin n_fail++;
                $display("FAIL fill_drain%0d: got valid=%b data=%h want valid=1 data=%h", i, m_valid, m_data, 32'h100 + i); end
            @(negedge pclk);
        end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++;
            $display("FAIL fill_empty: got occ=%0d want 0", occupancy); end
    endtask

    task automatic test_order_change();
        m_ready = 1'b1; delay_cycles = 32'd8; s_valid = 1'b1; s_data = 32'h1;
        @(negedge pclk);
        delay_cycles = 32'd0; s_data = 32'h2;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL order_k0: got valid=%b want 0", m_valid); end
        @(negedge pclk);
        s_valid = 1'b0;
        for (int k = 1; k < 8; k++) begin
            n_checks++; if (m_valid !== 1'b0) begin n_fail++;
                $display("FAIL order_hold_k%0d: got valid=%b data=%h want valid=0", k, m_valid, m_data); end
            @(negedge pclk);
        end
        n_checks++; if (m_valid !== 1'b1 || m_data !== 32'h1) begin n_fail++;
            $display("FAIL order_first: got valid=%b data=%h want valid=1 data=1", m_valid, m_data); end
        @(negedge pclk);
        n_checks++; if (m_valid !== 1'b1 || m_data !== 32'h2) begin n_fail++;
            $display("FAIL order_second: got valid=%b data=%h want valid=1 data=2", m_valid, m_data); end
        @(negedge pclk);
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL order_empty: got occ=%0d want 0", occupancy); end
    endtask

    task automatic test_backpressure();
        int t;
        m_ready = 1'b0; delay_cycles = 32'd2; s_valid = 1'b1; s_data = 32'hB1;
        @(negedge pclk);
        s_data = 32'hB2;
        @(negedge pclk);
        s_valid = 1'b0;
        t = 0;
        while (m_valid !== 1'b1 && t < 10) begin @(negedge pclk); t++; end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (m_valid !== 1'b1 || m_data !== 32'hB1 || occupancy !== 3'd2) begin n_fail++;
                $display("FAIL bp_hold%0d: got valid=%b data=%h occ=%0d want valid=1 data=b1 occ=2", k, m_valid, m_data, occupancy); end
            @(negedge pclk);
        end
        m_ready = 1'b1;
        @(negedge pclk);
        m_ready = 1'b0;
        n_checks++; if (occupancy !== 3'd1 || m_data !== 32'hB2) begin n_fail++;
            $display("FAIL bp_pop: got occ=%0d data=%h want occ=1 data=b2", occupancy, m_data); end
        @(negedge pclk);
        n_checks++; if (occupancy !== 3'd1 || m_valid !== 1'b1) begin n_fail++;
            $display("FAIL bp_single_pop: got occ=%0d valid=%b want occ=1 valid=1", occupancy, m_valid); end
        m_ready = 1'b1;
        @(negedge pclk);
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL bp_empty: got occ=%0d want 0", occupancy); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        m_ready = 1'b0; delay_cycles = 32'hFFFF_FFFF; s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 32'hC0 + i;
            @(negedge pclk);
        end
        s_valid = 1'b0;
        n_checks++; if (occupancy !== 3'd3 || m_valid !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_pre: got occ=%0d valid=%b want occ=3 valid=0", occupancy, m_valid); end
        #2 presetn = 1'b0;
        #1;
        n_checks++; if (m_valid !== 1'b0 || occupancy !== 3'd0 || s_ready !== 1'b1 || m_data !== 32'h0) begin n_fail++;
            $display("FAIL rst_mid_async: got valid=%b occ=%0d s_ready=%b data=%h want 0,0,1,0", m_valid, occupancy, s_ready, m_data); end
        @(negedge pclk);
        presetn = 1'b1; m_ready = 1'b1; delay_cycles = 32'd0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m_valid !== 1'b0 || occupancy !== 3'd0) seen = 1'b1;
            @(negedge pclk);
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale: got stale activity=%b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_zero_delay();
        test_fixed_delay();
        test_fill_full();
        test_order_change();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
